// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator.
package video_pkg;

  // Pattern selector values as driven on pattern_sel.
  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  // Generator sequencing states; ST_BLANK is only reachable with blanking built in.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_e;

  // Colour-bar channel masks {R,G,B}; each set bit becomes an all-ones channel.
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  // Map a bar index (0 = leftmost) to its channel mask.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = BAR_WHITE;
      3'd1:    rgb = BAR_YELLOW;
      3'd2:    rgb = BAR_CYAN;
      3'd3:    rgb = BAR_GREEN;
      3'd4:    rgb = BAR_MAGENTA;
      3'd5:    rgb = BAR_RED;
      3'd6:    rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_pattern_lut.sv
// Combinational pixel generator: pattern, position and solid colour -> pixel {R,G,B}.
module video_pattern_lut
  import video_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned H_ACTIVE    = 64,
  parameter int unsigned XW          = 6,
  parameter int unsigned YW          = 6
) (
  input  pattern_e                     pattern,
  input  logic [XW-1:0]                x,
  input  logic [YW-1:0]                y,
  input  logic [3*COLOR_WIDTH-1:0]     solid_color,
  output logic [3*COLOR_WIDTH-1:0]     pixel_c
);

  localparam int unsigned SW = XW + 3;

  logic [SW-1:0] x_scaled;
  logic [2:0]    bar_idx;
  logic [2:0]    bar_mask;
  logic          x_b3;
  logic          y_b3;

  // Bar index (x*8)/H_ACTIVE; bit 3 of x/y via shift so narrow counters read as 0.
  assign x_scaled = {x, 3'b000};
  assign bar_idx  = 3'(x_scaled / SW'(H_ACTIVE));
  assign bar_mask = bar_rgb(bar_idx);
  assign x_b3     = 1'(x >> 3);
  assign y_b3     = 1'(y >> 3);

  // Pattern select.
  always_comb begin
    pixel_c = '0;
    case (pattern)
      PAT_SOLID:   pixel_c = solid_color;
      PAT_BARS:    pixel_c = {{COLOR_WIDTH{bar_mask[2]}},
                              {COLOR_WIDTH{bar_mask[1]}},
                              {COLOR_WIDTH{bar_mask[0]}}};
      PAT_RAMP:    pixel_c = {3{COLOR_WIDTH'(x)}};
      PAT_CHECKER: pixel_c = (x_b3 ^ y_b3) ? '1 : '0;
      default:     pixel_c = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream video test-pattern generator (solid, bars, ramp, checkerboard).
// Optional inter-line blanking: define VIDEO_PATTERN_GEN_BLANKING_EN.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned H_ACTIVE    = 64,
  parameter int unsigned V_ACTIVE    = 48,
  parameter int unsigned H_BLANK     = 16
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         enable,
  input  logic [1:0]                   pattern_sel,
  input  logic [3*COLOR_WIDTH-1:0]     solid_color,
  output logic [3*COLOR_WIDTH-1:0]     video_out_tdata,
  output logic                         video_out_tvalid,
  input  logic                         video_out_tready,
  output logic                         video_out_tuser,
  output logic                         video_out_tlast,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int unsigned DW = 3 * COLOR_WIDTH;
  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
  localparam int unsigned BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);
  logic [BW-1:0] blank_q, blank_d;
`else
  logic unused_h_blank;
  assign unused_h_blank = ^32'(H_BLANK);
`endif

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  pattern_e      pat_q, pat_d;
  logic [DW-1:0] solid_q, solid_d;
  logic          done_d;
  logic          fire;
  logic [DW-1:0] pixel_c;
  logic [DW-1:0] tdata_d;
  logic          tvalid_d, tuser_d, tlast_d, busy_d;

  assign fire = video_out_tvalid && video_out_tready;

  // Next state, counters and latched configuration.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pat_d   = pat_q;
    solid_d = solid_q;
    done_d  = 1'b0;
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
    blank_d = blank_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          pat_d   = pattern_e'(pattern_sel);
          solid_d = solid_color;
          x_d     = '0;
          y_d     = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (fire) begin
          if (x_q != X_LAST) begin
            x_d = x_q + XW'(1);
          end else begin
            x_d = '0;
            if (y_q != Y_LAST) begin
              y_d = y_q + YW'(1);
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
              blank_d = '0;
              state_d = ST_BLANK;
`endif
            end else begin
              y_d    = '0;
              done_d = 1'b1;
              if (enable) begin
                pat_d   = pattern_e'(pattern_sel);
                solid_d = solid_color;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
      ST_BLANK: begin
        if (blank_q == B_LAST) state_d = ST_ACTIVE;
        else                   blank_d = blank_q + BW'(1);
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel for the beat that will be presented after this edge.
  video_pattern_lut #(
    .COLOR_WIDTH (COLOR_WIDTH),
    .H_ACTIVE    (H_ACTIVE),
    .XW          (XW),
    .YW          (YW)
  ) u_lut (
    .pattern     (pat_d),
    .x           (x_d),
    .y           (y_d),
    .solid_color (solid_d),
    .pixel_c     (pixel_c)
  );

  // Output stage next values; holding counters keeps the beat stable under backpressure.
  always_comb begin
    tvalid_d = (state_d == ST_ACTIVE);
    tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
    tlast_d  = tvalid_d && (x_d == X_LAST);
    tdata_d  = tvalid_d ? pixel_c : '0;
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter and configuration registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pat_q   <= PAT_SOLID;
      solid_q <= '0;
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pat_q   <= pat_d;
      solid_q <= solid_d;
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
      blank_q <= blank_d;
`endif
    end
  end

  // Registered stream and status outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      video_out_tdata  <= '0;
      video_out_tvalid <= 1'b0;
      video_out_tuser  <= 1'b0;
      video_out_tlast  <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      video_out_tdata  <= tdata_d;
      video_out_tvalid <= tvalid_d;
      video_out_tuser  <= tuser_d;
      video_out_tlast  <= tlast_d;
      busy             <= busy_d;
      frame_done       <= done_d;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen at H_ACTIVE=8, V_ACTIVE=4, COLOR_WIDTH=8.
module tb_video_pattern_gen;

  localparam int unsigned CW = 8;
  localparam int unsigned HA = 8;
  localparam int unsigned VA = 4;
  localparam int unsigned HB = 3;
  localparam int BUDGET = 2000;
`ifdef VIDEO_PATTERN_GEN_BLANKING_EN
  localparam int EXP_GAP = HB;
`else
  localparam int EXP_GAP = 0;
`endif

  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color;
  logic [23:0] video_out_tdata;
  logic        video_out_tvalid;
  logic        video_out_tready;
  logic        video_out_tuser;
  logic        video_out_tlast;
  logic        busy;
  logic        frame_done;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beats_seen = 0;
  bit    b2b_enable = 0;

  video_pattern_gen #(
    .COLOR_WIDTH (CW),
    .H_ACTIVE    (HA),
    .V_ACTIVE    (VA),
    .H_BLANK     (HB)
  ) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .enable           (enable),
    .pattern_sel      (pattern_sel),
    .solid_color      (solid_color),
    .video_out_tdata  (video_out_tdata),
    .video_out_tvalid (video_out_tvalid),
    .video_out_tready (video_out_tready),
    .video_out_tuser  (video_out_tuser),
    .video_out_tlast  (video_out_tlast),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pixel(input int pat, input int x, input int y,
                                            input logic [23:0] solid);
    logic [7:0] xb;
    xb = 8'(x);
    case (pat)
      0:       return solid;
      1:       return BAR_TAB[x];
      2:       return {xb, xb, xb};
      default: return ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [23:0] solid);
    beat_t b;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        b.data = exp_pixel(pat, x, y, solid);
        b.user = (x == 0) && (y == 0);
        b.last = (x == HA - 1);
        b.eof  = (x == HA - 1) && (y == VA - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (q.size() != 0 && cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats left expected 0", name, q.size());
      q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each transfer, checks stall stability, gaps and frame_done.
  bit          done_pending = 0;
  bit          b2b_check = 0;
  bit          gap_mode = 0;
  int          gap = 0;
  bit          prev_stall = 0;
  logic [25:0] prev_beat;
  always @(negedge clk) begin
    beat_t e;
    if (!aresetn) begin
      done_pending = 0;
      b2b_check    = 0;
      gap_mode     = 0;
      prev_stall   = 0;
    end else begin
      check("frame_done", 32'(frame_done), 32'(done_pending));
      done_pending = 0;
      if (b2b_check) begin
        check("b2b_tvalid_tuser", 32'({video_out_tvalid, video_out_tuser}), 32'h3);
        b2b_check = 0;
      end
      if (gap_mode) begin
        if (video_out_tvalid) begin
          check("line_gap", 32'(gap), 32'(EXP_GAP));
          gap_mode = 0;
        end else if (gap > EXP_GAP + 4) begin
          check("line_gap_overrun", 32'(gap), 32'(EXP_GAP));
          gap_mode = 0;
        end else begin
          gap++;
        end
      end
      if (prev_stall)
        check("stall_stable", 32'({video_out_tvalid, video_out_tdata, video_out_tuser, video_out_tlast}),
              32'({1'b1, prev_beat}));
      prev_stall = video_out_tvalid && !video_out_tready;
      prev_beat  = {video_out_tdata, video_out_tuser, video_out_tlast};
      if (video_out_tvalid && video_out_tready) begin
        if (q.size() == 0) begin
          check("extra_beat", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("beat", {6'b0, video_out_tdata, video_out_tuser, video_out_tlast},
                {6'b0, e.data, e.user, e.last});
          beats_seen++;
          if (e.last && !e.eof) begin
            gap_mode = 1;
            gap = 0;
          end
          if (e.eof) begin
            done_pending = 1;
            if (b2b_enable) b2b_check = 1;
          end
        end
      end
    end
  end

  task automatic start_frame(input logic [1:0] pat, input logic [23:0] solid, input bit hold);
    @(posedge clk); #1;
    pattern_sel = pat;
    solid_color = solid;
    enable      = 1'b1;
    @(posedge clk); #1;
    if (!hold) enable = 1'b0;
  endtask

  task automatic check_idle(input string name);
    #1;
    check({name, "_tvalid"}, 32'(video_out_tvalid), 32'(0));
    check({name, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int cyc;
    int stall_cnt;
    aresetn          = 1'b0;
    enable           = 1'b0;
    pattern_sel      = 2'd0;
    solid_color      = 24'h0;
    video_out_tready = 1'b1;
    #3;
    check("rst_outputs", 32'({video_out_tvalid, video_out_tuser, video_out_tlast, busy, frame_done}), 32'(0));
    check("rst_tdata", 32'(video_out_tdata), 32'(0));
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;

    // Solid colour, enable dropped during the frame.
    beats_seen = 0;
    push_frame(0, 24'h123456);
    start_frame(2'd0, 24'h123456, 1'b0);
    check("busy_active", 32'(busy), 32'(1));
    wait_drain("solid");
    check_idle("solid_end");

    // Colour bars with configuration changed mid-frame.
    push_frame(1, 24'h0);
    start_frame(2'd1, 24'h0, 1'b0);
    pattern_sel = 2'd2;
    solid_color = 24'hDEADBE;
    wait_drain("bars");
    check_idle("bars_end");

    // Ramp under random backpressure with a 5-cycle stall on x=3.
    beats_seen = 0;
    stall_cnt  = 0;
    push_frame(2, 24'h0);
    start_frame(2'd2, 24'h0, 1'b0);
    cyc = 0;
    while (q.size() != 0 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (beats_seen == 3 && video_out_tvalid && stall_cnt < 5) begin
        video_out_tready = 1'b0;
        stall_cnt++;
      end else begin
        video_out_tready = 1'($urandom_range(0, 1));
      end
    end
    video_out_tready = 1'b1;
    wait_drain("ramp_bp");
    check("stall_cycles", 32'(stall_cnt), 32'(5));
    check("ramp_transfers", 32'(beats_seen), 32'(32));
    @(posedge clk);
    check_idle("ramp_end");

    // Checkerboard then solid back-to-back with enable held.
    beats_seen = 0;
    b2b_enable = 1;
    push_frame(3, 24'h0);
    push_frame(0, 24'hA5C3E1);
    start_frame(2'd3, 24'h0, 1'b1);
    pattern_sel = 2'd0;
    solid_color = 24'hA5C3E1;
    cyc = 0;
    while (beats_seen < 33 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_reached", 32'(beats_seen >= 33), 32'(1));
    enable = 1'b0;
    b2b_enable = 0;
    wait_drain("b2b");
    check_idle("b2b_end");

    // Reset asserted mid-frame, then a fresh frame.
    beats_seen = 0;
    push_frame(0, 24'h777777);
    start_frame(2'd0, 24'h777777, 1'b0);
    cyc = 0;
    while (beats_seen < 12 && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reached", 32'(beats_seen), 32'(12));
    aresetn = 1'b0;
    #1;
    check("rst_mid_tvalid", 32'(video_out_tvalid), 32'(0));
    check("rst_mid_tdata", 32'(video_out_tdata), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    q.delete();
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(video_out_tvalid), 32'(0));
    push_frame(2, 24'h0);
    start_frame(2'd2, 24'h0, 1'b0);
    wait_drain("post_rst");
    check_idle("post_rst_end");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
